pkt_assembler_fifo: RTL

Parametrised successor to the single-park packet assembler. It filters and maps incoming events into SpiNNaker multicast packets, with optional 32-bit payload. Configurable filter/mapper counts and a FIFO_DEPTH output queue replace the one-entry park. Saturating filtered/dropped event counters feed the register bank. Sits between the event input pipe and the HSS multiplexer packet input.

---
 rtl/pkt_assembler_fifo.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pkt_assembler_fifo.sv
// Packet assembler with an output queue.
// Events are registered into a single stage (S1), filtered and mapped into
// a SpiNNaker multicast packet (optionally with payload) and pushed into a
// show-ahead FIFO that feeds the packet output. Filtered and dropped events
// are counted by saturating counters.
module pkt_assembler_fifo #(
  parameter int NUM_FLR    = 2,
  parameter int NUM_MPR    = 4,
  parameter int SFT_BITS   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [32*NUM_FLR-1:0]        fl_val_in,
  input  logic [32*NUM_FLR-1:0]        fl_msk_in,
  input  logic [31:0]                  mp_key_in,
  input  logic [32*NUM_MPR-1:0]        mp_fld_msk_in,
  input  logic [SFT_BITS*NUM_MPR-1:0]  mp_fld_sft_in,
  input  logic [32*NUM_MPR-1:0]        mp_fld_lmt_in,
  input  logic                         pld_mode_in,
  input  logic                         cnt_clr_in,
  input  logic [31:0]                  evt_data_in,
  input  logic [31:0]                  evt_pld_in,
  input  logic                         evt_vld_in,
  output logic                         evt_rdy_out,
  output logic [71:0]                  pkt_data_out,
  output logic                         pkt_vld_out,
  input  logic                         pkt_rdy_in,
  output logic [31:0]                  cnt_flt_out,
  output logic [31:0]                  cnt_drp_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // S1 stage
  logic        r_s1_vld;
  logic [31:0] r_s1_data;
  logic [31:0] r_s1_pld;
  logic        r_s1_mode;

  // Output queue
  logic [71:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic        r_evt_rdy;
  logic [31:0] r_cnt_flt;
  logic [31:0] r_cnt_drp;

  logic             w_accept;
  logic             w_hit;
  logic             w_drop;
  logic [31:0]      w_key;
  logic [31:0]      w_fld;
  logic [4:0]       w_amt;
  logic [31:0]      w_pld;
  logic [7:0]       w_hdr;
  logic [71:0]      w_pkt;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_room;

  assign w_accept = evt_vld_in && r_evt_rdy;

  // Capture each accepted event into S1; S1 empties by itself the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_pld  <= '0;
      r_s1_mode <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_data <= evt_data_in;
        r_s1_pld  <= evt_pld_in;
        r_s1_mode <= pld_mode_in;
      end
    end
  end

  // Filter match, field extraction, limit check and key assembly for S1.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_hit  = 1'b0;
    w_drop = 1'b0;
    w_key  = mp_key_in;
    w_fld  = '0;
    w_amt  = '0;
    for (int i = 0; i < NUM_FLR; i++) begin
      if ((r_s1_data & fl_msk_in[32*i +: 32]) == fl_val_in[32*i +: 32]) w_hit = 1'b1;
    end
    for (int j = 0; j < NUM_MPR; j++) begin
      w_amt = mp_fld_sft_in[SFT_BITS*j +: 5];
      // Direction bit set: the 5-bit field is a negative shift, i.e. shift left.
      if (mp_fld_sft_in[SFT_BITS*j + SFT_BITS - 1])
        w_fld = (r_s1_data & mp_fld_msk_in[32*j +: 32]) << (~w_amt + 5'd1);
      else
        w_fld = (r_s1_data & mp_fld_msk_in[32*j +: 32]) >> w_amt;
      if (w_fld > mp_fld_lmt_in[32*j +: 32]) w_drop = 1'b1;
      w_key = w_key | w_fld;
    end
  end

  // Header: payload flag plus a parity bit making the whole packet odd parity.
  assign w_pld  = r_s1_mode ? r_s1_pld : 32'h0;
  assign w_hdr  = {6'b0, r_s1_mode, ~(^w_key ^ ^w_pld ^ r_s1_mode)};
  assign w_pkt  = {w_pld, w_key, w_hdr};

  assign w_push      = r_s1_vld && !w_hit && !w_drop;
  assign pkt_vld_out = (r_count != '0);
  assign w_pop       = pkt_vld_out && pkt_rdy_in;

  // Occupancy after this edge.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  // One free slot must remain beyond the queue and whatever S1 will hold.
  assign w_room = ({1'b0, w_count_nxt} + {{CNT_W{1'b0}}, w_accept}) < {1'b0, DEPTH_C};

  // Queue storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers and count alone define validity.
    if (w_push) r_mem[r_wr_ptr] <= w_pkt;
  end

  // Queue pointers, occupancy and registered event-ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_evt_rdy <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_nxt;
      r_evt_rdy <= w_room;
    end
  end

  // Saturating event counters; clear takes priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_flt <= '0;
      r_cnt_drp <= '0;
    end else if (cnt_clr_in) begin
      r_cnt_flt <= '0;
      r_cnt_drp <= '0;
    end else if (r_s1_vld) begin
      if (w_hit) begin
        if (r_cnt_flt != '1) r_cnt_flt <= r_cnt_flt + 1'b1;
      end else if (w_drop) begin
        if (r_cnt_drp != '1) r_cnt_drp <= r_cnt_drp + 1'b1;
      end
    end
  end

  assign pkt_data_out = r_mem[r_rd_ptr];
  assign evt_rdy_out  = r_evt_rdy;
  assign cnt_flt_out  = r_cnt_flt;
  assign cnt_drp_out  = r_cnt_drp;

  // The flow-control reservation makes a push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == DEPTH_C) && !w_pop));

endmodule
